seq_magnitude_comparator: RTL and testbench
===========================================

Name: seq_magnitude_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator. Successor to the 4-bit combinational comparator.
- Compares two WIDTH-bit operands CHUNK bits per cycle, starting at the MSB chunk. Terminates early at the first differing chunk.
- Valid/ready handshakes on input and output, so it sits between pipelined datapath stages. It replaces a wide combinational compare on timing-critical paths.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle. 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived local parameter. Not overridable.
- CW, $clog2(NCHUNK+1), derived local parameter: width of the chunks count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  g/l/e/chunks hold a result.
- out_ready  input  1  consumer accepts the result.
- g  output  1  A > B.
- l  output  1  A < B.
- e  output  1  A == B.
- chunks  output  CW  number of chunks examined to reach the decision (1..NCHUNK).

Behaviour:
- Reset (asynchronous, takes effect immediately, any state):
  - state = IDLE.
  - g = l = e = 0, chunks = 0, out_valid = 0, internal operand registers = 0.
  - in_ready = 1 once in IDLE.
- States: IDLE, SCAN, DONE. in_ready = (state == IDLE); out_valid = (state == DONE). Both are decoded from registered state only, with no combinational path from in_valid or out_ready.
- IDLE:
  - On in_valid & in_ready: capture a and b, set idx = NCHUNK-1, clear chunks, clear g/l/e, go to SCAN.
  - Otherwise remain in IDLE.
- SCAN, one edge per chunk. Compare A[idx*CHUNK +: CHUNK] against B[idx*CHUNK +: CHUNK] as unsigned values, and increment chunks.
  - Chunks differ: set g or l, go to DONE.
  - Chunks equal and idx == 0: set e = 1, go to DONE.
  - Otherwise: idx = idx-1, stay in SCAN.
- Exactly one of g/l/e is 1 whenever out_valid = 1.
- Latency: out_valid rises k edges after the accepting edge, where k = chunks (1 to NCHUNK).
- DONE:
  - Hold g/l/e/chunks stable while out_ready = 0.
  - On out_ready = 1, go to IDLE. g/l/e/chunks keep their values until the next acceptance.
- Throughput:
  - Minimum 1 idle cycle between a result handshake and the next acceptance.
  - Per-operation cost = k + 2 cycles at best.
- in_valid is ignored outside IDLE. a and b may change freely after acceptance.
- CHUNK == WIDTH degenerates to a single-cycle scan (k = 1 always).

Optional Feature:
- Macro: CMP_SIGNED_EN.
- Defined:
  - Adds port signed_mode (input, 1), sampled at acceptance.
  - When the captured value is 1, operands are two's complement. The MSB of both captured operands is inverted before the scan, so the unsigned chunk compare yields the signed ordering.
  - When the captured value is 0, behaviour is identical to the undefined case.
- Undefined: port absent; unsigned comparison only.

Test Plan:
- WIDTH=16, CHUNK=4. Accept a=0x8000, b=0x7FFF. Expect out_valid 1 edge after acceptance, g=1, l=0, e=0, chunks=1.
- a=0x1234, b=0x1235. Expect l=1, chunks=4, out_valid 4 edges after acceptance.
- a=b=0xABCD. Expect e=1, g=l=0, chunks=4.
- Hold out_ready=0 for 3 cycles after a result while pulsing in_valid with new operands. Expect g/l/e/chunks stable, in_ready=0, no new capture. After out_ready=1: IDLE, in_ready=1 the following cycle.
- Assert rst during SCAN, mid-edge (asynchronously). Expect out_valid=0 and g=l=e=chunks=0 immediately, in_ready=1. A new operation after release completes correctly.
- CMP_SIGNED_EN defined, a=0x8000, b=0x0001:
  - signed_mode=1: l=1, chunks=1.
  - signed_mode=0: g=1, chunks=1.

Source files
------------

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans CHUNK bits per cycle from the MSB
// and stops at the first differing chunk. Define CMP_SIGNED_EN for signed_mode.
module seq_magnitude_comparator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [WIDTH-1:0]                        a,
  input  logic [WIDTH-1:0]                        b,
`ifdef CMP_SIGNED_EN
  input  logic                                    signed_mode,
`endif
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    g,
  output logic                                    l,
  output logic                                    e,
  output logic [$clog2((WIDTH/CHUNK)+1)-1:0]      chunks
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = $clog2(NCHUNK + 1);
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_cap;
  logic [WIDTH-1:0] b_cap;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;

  // Operand conditioning at capture: MSB flip maps two's complement onto unsigned order
  always_comb begin
    a_cap = a;
    b_cap = b;
`ifdef CMP_SIGNED_EN
    if (signed_mode) begin
      a_cap[WIDTH-1] = ~a[WIDTH-1];
      b_cap[WIDTH-1] = ~b[WIDTH-1];
    end
`endif
  end

  // Select the chunk pair currently under examination
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < int'(NCHUNK); i++) begin
      if (idx == IW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  // Control FSM with registered handshake flags and result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx       <= '0;
      chunks    <= '0;
      g         <= 1'b0;
      l         <= 1'b0;
      e         <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a_cap;
            b_q      <= b_cap;
            idx      <= IW'(NCHUNK - 1);
            chunks   <= '0;
            g        <= 1'b0;
            l        <= 1'b0;
            e        <= 1'b0;
            in_ready <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          chunks <= chunks + CW'(1);
          if (a_chunk > b_chunk) begin
            g         <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (a_chunk < b_chunk) begin
            l         <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (idx == '0) begin
            e         <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator (WIDTH=16, CHUNK=4) against
// an arithmetic reference model; exercises signed_mode when CMP_SIGNED_EN is defined.
module tb_seq_magnitude_comparator;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CHUNK  = 4;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = $clog2(NCHUNK + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             g;
  logic             l;
  logic             e;
  logic [CW-1:0]    chunks;
`ifdef CMP_SIGNED_EN
  logic             signed_mode;
`endif

  int n_checks = 0;
  int n_errors = 0;

  seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef CMP_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .g         (g),
    .l         (l),
    .e         (e),
    .chunks    (chunks)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: ordering from integer compare, chunk count from highest differing bit
  task automatic model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input bit sm,
                       output bit eg, output bit el, output bit ee, output int ec);
    int p;
    int sa;
    int sb;
    p = -1;
    for (int i = 0; i < int'(WIDTH); i++)
      if (av[i] != bv[i]) p = i;
    sa = sm ? int'($signed(av)) : int'({16'd0, av});
    sb = sm ? int'($signed(bv)) : int'({16'd0, bv});
    eg = (sa > sb);
    el = (sa < sb);
    ee = (sa == sb);
    ec = (p < 0) ? int'(NCHUNK) : int'(NCHUNK) - p / int'(CHUNK);
  endtask

  // One full transaction; optionally stall the result for hold cycles
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input bit sm, input int hold, input string tag);
    bit eg, el, ee;
    int ec;
    int lat;
    int waitc;
    model(av, bv, sm, eg, el, ee, ec);
    waitc = 0;
    while (!in_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = av;
    b = bv;
`ifdef CMP_SIGNED_EN
    signed_mode = sm;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
`ifdef CMP_SIGNED_EN
    signed_mode = ~sm;
`endif
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(ec));
    check({tag, "_g"}, 32'(g), 32'(eg));
    check({tag, "_l"}, 32'(l), 32'(el));
    check({tag, "_e"}, 32'(e), 32'(ee));
    check({tag, "_chunks"}, 32'(chunks), 32'(ec));
    for (int h = 0; h < hold; h++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_res"}, {28'(chunks), g, l, e}, {28'(ec), eg, el, ee});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_post_res"}, {28'(chunks), g, l, e}, {28'(ec), eg, el, ee});
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
`ifdef CMP_SIGNED_EN
    signed_mode = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_res", {28'(chunks), g, l, e}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h8000, 16'h7FFF, 1'b0, 0, "msb_gt");
    run_op(16'h1234, 16'h1235, 1'b0, 0, "lsb_lt");
    run_op(16'hABCD, 16'hABCD, 1'b0, 0, "equal");
    run_op(16'h0000, 16'h0000, 1'b0, 0, "zeros");
    run_op(16'hFFFF, 16'hFFF0, 1'b0, 0, "low_chunk_gt");
    run_op(16'h12F4, 16'h1204, 1'b0, 2, "mid_gt_hold2");
    run_op(16'h5555, 16'h5A55, 1'b0, 3, "hold3");

    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(3, 0))
        0: rb = WIDTH'($urandom);
        1: rb = ra;
        2: rb = ra ^ WIDTH'(32'd1 << $urandom_range(WIDTH - 1, 0));
        default: rb = {ra[WIDTH-1:CHUNK], CHUNK'($urandom)};
      endcase
      run_op(ra, rb, 1'b0, int'($urandom_range(2, 0)), "rand");
    end

    // Asynchronous reset landing mid-scan
    @(negedge clk);
    a = 16'h1234;
    b = 16'h1235;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_res", {28'(chunks), g, l, e}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(16'h0F00, 16'h0E00, 1'b0, 0, "after_rst");

`ifdef CMP_SIGNED_EN
    run_op(16'h8000, 16'h0001, 1'b1, 0, "signed_neg_lt");
    run_op(16'h8000, 16'h0001, 1'b0, 0, "unsigned_gt");
    for (int n = 0; n < 20; n++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0, "rand_signed");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so a stuck handshake still reaches the summary
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
